// File: rtl/lns_addsub_pipe.sv
// Two-stage LNS adder/subtractor driving an external correction LUT.
// S1 aligns the operands and addresses the LUT; S2 applies the correction, saturates and holds the result.
module lns_addsub_pipe #(
    parameter int LW = 16,
    parameter int SH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 a_zero,
    input  logic                 a_sign,
    input  logic signed [LW-1:0] a_log,
    input  logic                 b_zero,
    input  logic                 b_sign,
    input  logic signed [LW-1:0] b_log,
    input  logic                 sub,
    output logic                 lut_sel,
    output logic [6:0]           lut_z,
    input  logic signed [10:0]   lut_corr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 r_zero,
    output logic                 r_sign,
    output logic signed [LW-1:0] r_log,
    output logic                 r_ovf
);

    localparam logic [LW:0] IDX_ADD_MAX = (LW+1)'(127);
    localparam logic [LW:0] IDX_SUB_MAX = (LW+1)'(31);

    logic                 r_s1_valid;
    logic                 r_s1_add;
    logic                 r_s1_a_zero;
    logic                 r_s1_b_zero;
    logic                 r_s1_sign;
    logic signed [LW-1:0] r_s1_log;
    logic [LW:0]          r_s1_d;

    logic                 w_s1_adv;
    logic                 w_accept;
    logic                 w_sb;
    logic                 w_a_large;
    logic                 w_add;
    logic [LW:0]          w_diff;
    logic [LW:0]          w_d;
    logic [LW:0]          w_idx;
    logic                 w_sel_sign;
    logic signed [LW-1:0] w_sel_log;

    assign w_s1_adv  = r_s1_valid && (!out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;
    assign w_sb      = b_sign ^ sub;
    assign w_a_large = (a_log >= b_log);
    assign w_add     = (a_sign == w_sb);
    assign w_diff    = {a_log[LW-1], a_log} - {b_log[LW-1], b_log};
    assign w_d       = w_diff[LW] ? (~w_diff + 1'b1) : w_diff;

    // With exactly one zero operand the S1 "large" slot carries the surviving operand instead.
    always_comb begin
        w_sel_sign = w_a_large ? a_sign : w_sb;
        w_sel_log  = w_a_large ? a_log : b_log;
        if (a_zero) begin
            w_sel_sign = w_sb;
            w_sel_log  = b_log;
        end else if (b_zero) begin
            w_sel_sign = a_sign;
            w_sel_log  = a_log;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_add    <= 1'b0;
            r_s1_a_zero <= 1'b0;
            r_s1_b_zero <= 1'b0;
            r_s1_sign   <= 1'b0;
            r_s1_log    <= '0;
            r_s1_d      <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid  <= 1'b1;
                r_s1_add    <= w_add;
                r_s1_a_zero <= a_zero;
                r_s1_b_zero <= b_zero;
                r_s1_sign   <= w_sel_sign;
                r_s1_log    <= w_sel_log;
                r_s1_d      <= w_d;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign w_idx = r_s1_d >> SH;

    always_comb begin
        lut_sel = 1'b0;
        lut_z   = '0;
        if (r_s1_valid) begin
            lut_sel = r_s1_add;
            if (r_s1_add) begin
                lut_z = (w_idx > IDX_ADD_MAX) ? 7'd127 : w_idx[6:0];
            end else begin
                lut_z = (w_idx > IDX_SUB_MAX) ? 7'd31 : w_idx[6:0];
            end
        end
    end

    logic signed [LW:0]   w_sum;
    logic                 w_pos_ovf;
    logic                 w_neg_ovf;
    logic                 w_nx_zero;
    logic                 w_nx_sign;
    logic signed [LW-1:0] w_nx_log;
    logic                 w_nx_ovf;

    // One guard bit is enough: the 11-bit correction cannot move an LW-bit log past LW+1 bits.
    assign w_sum     = {r_s1_log[LW-1], r_s1_log} + {{(LW-10){lut_corr[10]}}, lut_corr};
    assign w_pos_ovf = !w_sum[LW] && w_sum[LW-1];
    assign w_neg_ovf = w_sum[LW] && !w_sum[LW-1];

    always_comb begin
        w_nx_zero = 1'b0;
        w_nx_sign = r_s1_sign;
        w_nx_log  = w_sum[LW-1:0];
        w_nx_ovf  = 1'b0;
        if ((r_s1_a_zero && r_s1_b_zero) ||
            (!r_s1_a_zero && !r_s1_b_zero && !r_s1_add && (r_s1_d == '0))) begin
            w_nx_zero = 1'b1;
            w_nx_sign = 1'b0;
            w_nx_log  = '0;
        end else if (r_s1_a_zero || r_s1_b_zero) begin
            w_nx_log = r_s1_log;
        end else if (w_pos_ovf) begin
            w_nx_log = {1'b0, {(LW-1){1'b1}}};
            w_nx_ovf = 1'b1;
        end else if (w_neg_ovf) begin
            w_nx_log = {1'b1, {(LW-1){1'b0}}};
            w_nx_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            r_zero    <= 1'b0;
            r_sign    <= 1'b0;
            r_log     <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                out_valid <= 1'b1;
                r_zero    <= w_nx_zero;
                r_sign    <= w_nx_sign;
                r_log     <= w_nx_log;
                r_ovf     <= w_nx_ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lns_addsub_pipe.sv
// Scoreboard bench for lns_addsub_pipe: directed corner cases plus randomized traffic with random backpressure.
// The correction tables are synthetic stand-ins chosen to match the reference examples.
module tb_lns_addsub_pipe;
    localparam int LW = 16;
    localparam int SH = 6;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 a_zero = 1'b0;
    logic                 a_sign = 1'b0;
    logic signed [LW-1:0] a_log = '0;
    logic                 b_zero = 1'b0;
    logic                 b_sign = 1'b0;
    logic signed [LW-1:0] b_log = '0;
    logic                 sub = 1'b0;
    logic                 lut_sel;
    logic [6:0]           lut_z;
    logic signed [10:0]   lut_corr;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic                 r_zero;
    logic                 r_sign;
    logic signed [LW-1:0] r_log;
    logic                 r_ovf;

    lns_addsub_pipe #(.LW(LW), .SH(SH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_zero(a_zero), .a_sign(a_sign), .a_log(a_log),
        .b_zero(b_zero), .b_sign(b_sign), .b_log(b_log),
        .sub(sub),
        .lut_sel(lut_sel), .lut_z(lut_z), .lut_corr(lut_corr),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_zero(r_zero), .r_sign(r_sign), .r_log(r_log), .r_ovf(r_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit zero;
        bit sign;
        int lg;
        bit ovf;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;
    int   n_acc = 0;
    int   n_out = 0;
    bit   rand_ready = 1'b0;

    function automatic int f4(int z);
        return (z * 37) % 700 - 376;
    endfunction

    function automatic int f3(int z);
        return -((z * 53) % 900) - 13;
    endfunction

    always_comb lut_corr = 11'(lut_sel ? f4(int'(lut_z)) : f3(int'(lut_z)));

    function automatic exp_t model(bit az, bit asg, int al, bit bz, bit bsg, int bl, bit sb_in);
        exp_t e;
        bit   eb, add_m, lsgn;
        int   d, z, s, lg;
        e.zero = 0; e.sign = 0; e.lg = 0; e.ovf = 0;
        eb = bsg ^ sb_in;
        if (az && bz) begin
            e.zero = 1;
            return e;
        end
        if (az) begin
            e.sign = eb; e.lg = bl;
            return e;
        end
        if (bz) begin
            e.sign = asg; e.lg = al;
            return e;
        end
        add_m = (asg == eb);
        d = (al > bl) ? al - bl : bl - al;
        if (al >= bl) begin lg = al; lsgn = asg; end
        else          begin lg = bl; lsgn = eb;  end
        if (!add_m && d == 0) begin
            e.zero = 1;
            return e;
        end
        z = d >> SH;
        if (add_m && z > 127) z = 127;
        if (!add_m && z > 31) z = 31;
        s = lg + (add_m ? f4(z) : f3(z));
        if (s > 32767) begin s = 32767; e.ovf = 1; end
        else if (s < -32768) begin s = -32768; e.ovf = 1; end
        e.sign = lsgn;
        e.lg = s;
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send(bit az, bit asg, int al, bit bz, bit bsg, int bl, bit sb_in);
        bit done = 0;
        a_zero = az; a_sign = asg; a_log = 16'(al);
        b_zero = bz; b_sign = bsg; b_log = 16'(bl);
        sub = sb_in;
        in_valid = 1'b1;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                sb_q.push_back(model(az, asg, al, bz, bsg, bl, sb_in));
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept in 60 cycles, expected in_ready");
        end
    endtask

    // Outputs are sampled mid-cycle; a transfer happens at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (out_valid && !out_ready && sb_q.size() != 0) begin
                check("stall_r_log", r_log, sb_q[0].lg);
                check("stall_r_zero", r_zero, sb_q[0].zero);
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got result log %0d, expected none", r_log);
                end else begin
                    e = sb_q.pop_front();
                    check("r_zero", r_zero, e.zero);
                    check("r_sign", r_sign, e.sign);
                    check("r_log", r_log, e.lg);
                    check("r_ovf", r_ovf, e.ovf);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(3) != 0);
        end
    end

    task automatic drain();
        for (int t = 0; t < 100 && sb_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        int n0, o0, al, bl, md;
        bit az, bz, asg, bsg, sb_r;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_r_zero", r_zero, 0);
        check("rst_r_log", r_log, 0);
        check("rst_r_ovf", r_ovf, 0);
        check("rst_lut_sel", lut_sel, 0);
        check("rst_lut_z", lut_z, 0);
        @(posedge clk); #3 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", in_ready, 1);
        @(posedge clk); #1;

        send(0, 0, 2048, 0, 0, 1984, 0);
        check("add_lut_sel", lut_sel, 1);
        check("add_lut_z", lut_z, 1);
        check("add_latency_early", out_valid, 0);
        @(posedge clk); #1;
        check("add_latency_valid", out_valid, 1);
        check("add_r_log", r_log, 1709);
        check("add_r_sign", r_sign, 0);
        check("add_r_ovf", r_ovf, 0);

        send(0, 0, 1000, 0, 0, 1000, 1);
        @(posedge clk); #1;
        check("cancel_r_zero", r_zero, 1);
        check("cancel_r_log", r_log, 0);
        send(0, 1, 640, 0, 1, 0, 1);
        check("sub_lut_sel", lut_sel, 0);
        check("sub_lut_z", lut_z, 10);
        @(posedge clk); #1;
        check("sub_r_sign", r_sign, 1);
        check("sub_r_log", r_log, 97);

        send(1, 0, 0, 0, 0, -300, 1);
        @(posedge clk); #1;
        check("bypass_r_zero", r_zero, 0);
        check("bypass_r_sign", r_sign, 1);
        check("bypass_r_log", r_log, -300);
        send(1, 0, 0, 1, 0, 0, 0);
        @(posedge clk); #1;
        check("both_zero_r_zero", r_zero, 1);
        check("both_zero_r_sign", r_sign, 0);

        send(0, 0, -32768, 0, 0, -32704, 0);
        check("sat_lut_z", lut_z, 1);
        @(posedge clk); #1;
        check("sat_r_log", r_log, -32768);
        check("sat_r_ovf", r_ovf, 1);
        drain();

        // Four back-to-back inputs against a stalled output.
        out_ready = 1'b0;
        n0 = n_acc;
        fork
            begin
                send(0, 0, 5000, 0, 0, 4000, 0);
                send(0, 1, 300, 0, 0, 900, 1);
                send(0, 0, -700, 1, 0, 0, 0);
                send(0, 0, 12000, 0, 1, 11000, 0);
            end
        join_none
        repeat (5) @(posedge clk);
        #1;
        check("bp_accepts", n_acc - n0, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        o0 = n_out;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_burst_outputs", n_out - o0, 4);
        drain();

        out_ready = 1'b0;
        send(0, 0, 100, 0, 0, 50, 0);
        send(0, 1, 2000, 0, 0, 1500, 0);
        #3 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_lut_sel", lut_sel, 0);
        check("midrst_lut_z", lut_z, 0);
        check("midrst_r_log", r_log, 0);
        sb_q.delete();
        @(negedge clk); #2 rst = 1'b0;
        out_ready = 1'b1;
        o0 = n_out;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_output", n_out - o0, 0);

        rand_ready = 1'b1;
        repeat (300) begin
            az = ($urandom_range(7) == 0);
            bz = ($urandom_range(7) == 0);
            asg = 1'($urandom_range(1));
            bsg = 1'($urandom_range(1));
            sb_r = 1'($urandom_range(1));
            al = int'($urandom_range(65535)) - 32768;
            if ($urandom_range(7) == 0) al = 32767 - int'($urandom_range(500));
            else if ($urandom_range(7) == 0) al = -32768 + int'($urandom_range(500));
            md = int'($urandom_range(3));
            case (md)
                0: bl = int'($urandom_range(65535)) - 32768;
                1: bl = al + int'($urandom_range(256)) - 128;
                2: bl = al;
                default: bl = al + int'($urandom_range(4096)) - 2048;
            endcase
            if (bl > 32767) bl = 32767;
            if (bl < -32768) bl = -32768;
            if ($urandom_range(4) == 0) begin
                @(posedge clk); #1;
            end
            send(az, asg, al, bz, bsg, bl, sb_r);
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
